// File: rtl/tt_sweep_gen_pkg.sv
//------------------------------------------------------------------------------
// tt_sweep_pkg
// Shared types and constants for the truth-table sweeper (tt_sweep_gen).
//   state_t     : sweep FSM states
//   SETTLE_MIN  : smallest legal settle time in cycles
//   N_IN_MIN/MAX: legal range of gate input count
//   vec_count() : number of input vectors for an N-input gate
//   cnt_width() : bit width needed by the settle down-counter
//------------------------------------------------------------------------------
package tt_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      APPLY  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int SETTLE_MIN = 1;
   localparam int N_IN_MIN   = 1;
   localparam int N_IN_MAX   = 6;

   // Number of input vectors swept for an n-input gate.
   function automatic int vec_count(input int n);
      return 1 << n;
   endfunction

   // Width of a down-counter that must hold settle-1 (at least one bit).
   function automatic int cnt_width(input int settle);
      if (settle <= 2) begin
         return 1;
      end else begin
         return $clog2(settle);
      end
   endfunction

endpackage

// File: rtl/tt_sweep_gen_if.sv
//------------------------------------------------------------------------------
// tt_sweep_gen_if
// Bundles the sweeper's control, gate-facing and result signals.
//   start/expected : sweep request and expected truth table (environment -> sweeper)
//   vec_out/vec_valid : vector driven to the gate under test
//   dut_y          : gate output fed back into the sweeper
//   busy/done      : sweep status, done is a one-cycle pulse
//   table_out/err_count/fail_vec/pass : measured results
// Modports: master = environment/gate side, slave = the sweeper.
//------------------------------------------------------------------------------
interface tt_sweep_gen_if #(
   parameter int N_IN = 2
);
   localparam int NVEC = 1 << N_IN;

   logic              start;
   logic [NVEC-1:0]   expected;
   logic [N_IN-1:0]   vec_out;
   logic              vec_valid;
   logic              dut_y;
   logic              busy;
   logic              done;
   logic [NVEC-1:0]   table_out;
   logic [N_IN:0]     err_count;
   logic [N_IN-1:0]   fail_vec;
   logic              pass;

   modport master (
      output start, expected, dut_y,
      input  vec_out, vec_valid, busy, done, table_out, err_count, fail_vec, pass
   );

   modport slave (
      input  start, expected, dut_y,
      output vec_out, vec_valid, busy, done, table_out, err_count, fail_vec, pass
   );

endinterface

// File: rtl/tt_sweep_gen_settle_cnt.sv
//------------------------------------------------------------------------------
// tt_settle_cnt
// Loadable down-counter timing how long a vector is held before sampling.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load load_val (has priority over counting)
//   load_val   : value loaded, settle-1 so that expire fires after settle cycles
//   en         : count enable, high while the vector is being held
//   expire     : one-cycle strobe in the last enabled cycle (count reached 0)
//------------------------------------------------------------------------------
module tt_settle_cnt #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         expire
);

   logic [W-1:0] cnt_r;

   // Down-counter: load wins, then decrement while enabled, stopping at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r <= {W{1'b0}};
      end else if (load) begin
         cnt_r <= load_val;
      end else if (en && (cnt_r != {W{1'b0}})) begin
         cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Decoded straight from the count register, so it is glitch-free in practice.
   assign expire = en && (cnt_r == {W{1'b0}});

endmodule

// File: rtl/tt_sweep_gen.sv
//------------------------------------------------------------------------------
// tt_sweep_gen
// Truth-table sweeper: drives every input vector of an N_IN-input combinational
// gate in ascending order, samples the gate output after SETTLE cycles, builds
// the measured truth table and compares it with an expected mask.
//   clk, rst_n : clock, synchronous active-low reset
//   sw (slave) : start/expected in, vec_out/vec_valid to the gate, dut_y back,
//                busy/done status, table_out/err_count/fail_vec/pass results
// Parameters: N_IN (1..6) gate inputs, SETTLE (>=1) hold cycles per vector.
// Build option: define TT_SWEEP_STOP_ON_ERR_EN to end the sweep at the first
// mismatching vector; by default the full sweep always runs.
//------------------------------------------------------------------------------
module tt_sweep_gen
   import tt_sweep_pkg::*;
#(
   parameter int N_IN   = 2,
   parameter int SETTLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   tt_sweep_gen_if.slave sw
);

   localparam int NVEC       = vec_count(N_IN);
   localparam int SETTLE_EFF = (SETTLE < SETTLE_MIN) ? SETTLE_MIN : SETTLE;
   localparam int SET_W      = cnt_width(SETTLE_EFF);

   localparam logic [N_IN-1:0]  LAST_VEC    = {N_IN{1'b1}};
   localparam logic [N_IN-1:0]  ONE_VEC     = N_IN'(1);
   localparam logic [N_IN:0]    ONE_ERR     = (N_IN+1)'(1);
   localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_EFF - 1);

   state_t            state_r;
   state_t            state_nxt_s;

   logic [N_IN-1:0]   vec_r;
   logic [NVEC-1:0]   exp_r;
   logic [NVEC-1:0]   table_r;
   logic [N_IN:0]     err_r;
   logic [N_IN-1:0]   fail_r;
   logic              pass_r;

   logic [N_IN-1:0]   vec_out_r;
   logic              valid_r;
   logic              busy_r;
   logic              done_r;

   logic              accept_s;
   logic              sample_s;
   logic              mismatch_s;
   logic              last_s;
   logic              stop_s;
   logic              settle_load_s;
   logic              settle_en_s;
   logic              expire_s;

   tt_settle_cnt #(
      .W (SET_W)
   ) u_settle_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (settle_load_s),
      .load_val (SETTLE_LOAD),
      .en       (settle_en_s),
      .expire   (expire_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode and per-state control strobes.
   always_comb begin
      state_nxt_s   = state_r;
      accept_s      = 1'b0;
      sample_s      = 1'b0;
      settle_load_s = 1'b0;
      settle_en_s   = 1'b0;
      mismatch_s    = (sw.dut_y != exp_r[vec_r]);
      last_s        = (vec_r == LAST_VEC);
`ifdef TT_SWEEP_STOP_ON_ERR_EN
      stop_s        = mismatch_s;
`else
      stop_s        = 1'b0;
`endif
      case (state_r)
         IDLE: begin
            if (sw.start) begin
               accept_s      = 1'b1;
               settle_load_s = 1'b1;
               state_nxt_s   = APPLY;
            end else begin
               state_nxt_s   = IDLE;
            end
         end
         APPLY: begin
            settle_en_s = 1'b1;
            if (expire_s) begin
               state_nxt_s = SAMPLE;
            end else begin
               state_nxt_s = APPLY;
            end
         end
         SAMPLE: begin
            sample_s = 1'b1;
            // The counter never wraps: the last vector always ends the sweep.
            if (last_s || stop_s) begin
               state_nxt_s = DONE;
            end else begin
               settle_load_s = 1'b1;
               state_nxt_s   = APPLY;
            end
         end
         DONE: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Sweep datapath: vector counter, expected latch, table and error tracking.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vec_r   <= {N_IN{1'b0}};
         exp_r   <= {NVEC{1'b0}};
         table_r <= {NVEC{1'b0}};
         err_r   <= {(N_IN+1){1'b0}};
         fail_r  <= {N_IN{1'b0}};
         pass_r  <= 1'b0;
      end else if (accept_s) begin
         vec_r   <= {N_IN{1'b0}};
         exp_r   <= sw.expected;
         table_r <= {NVEC{1'b0}};
         err_r   <= {(N_IN+1){1'b0}};
         fail_r  <= {N_IN{1'b0}};
         pass_r  <= 1'b0;
      end else if (sample_s) begin
         table_r[vec_r] <= sw.dut_y;
         if (mismatch_s) begin
            err_r <= err_r + ONE_ERR;
            // err_r still zero means this is the first mismatch of the sweep.
            if (err_r == {(N_IN+1){1'b0}}) begin
               fail_r <= vec_r;
            end else begin
               fail_r <= fail_r;
            end
         end else begin
            err_r  <= err_r;
            fail_r <= fail_r;
         end
         if (!(last_s || stop_s)) begin
            vec_r <= vec_r + ONE_VEC;
         end else begin
            vec_r <= vec_r;
         end
      end else if (state_r == DONE) begin
         // pass is captured together with the done pulse and then held.
         pass_r <= (err_r == {(N_IN+1){1'b0}});
      end else begin
         pass_r <= pass_r;
      end
   end

   // Registered status outputs; they trail the state register by one cycle,
   // so vector 0 reaches the gate one cycle after the start is accepted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vec_out_r <= {N_IN{1'b0}};
         valid_r   <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         if ((state_r == APPLY) || (state_r == SAMPLE)) begin
            vec_out_r <= vec_r;
            valid_r   <= 1'b1;
            busy_r    <= 1'b1;
         end else begin
            vec_out_r <= {N_IN{1'b0}};
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
         end
         done_r <= (state_r == DONE);
      end
   end

   assign sw.vec_out   = vec_out_r;
   assign sw.vec_valid = valid_r;
   assign sw.busy      = busy_r;
   assign sw.done      = done_r;
   assign sw.table_out = table_r;
   assign sw.err_count = err_r;
   assign sw.fail_vec  = fail_r;
   assign sw.pass      = pass_r;

endmodule

// File: tb/tb_tt_sweep_gen.sv
//------------------------------------------------------------------------------
// tb_tt_sweep_gen
// Self-checking bench for tt_sweep_gen. Two instances: A (N_IN=2, SETTLE=1)
// and B (N_IN=3, SETTLE=2), each driving a gate modelled as a truth-table
// lookup. Expected results come from a truth-table model of the sweep.
//------------------------------------------------------------------------------
module tb_tt_sweep_gen;

   logic clk;
   logic rst_n;

   tt_sweep_gen_if #(.N_IN(2)) a_if ();
   tt_sweep_gen_if #(.N_IN(3)) b_if ();

   logic [3:0] a_gate;
   logic [7:0] b_gate;

   tt_sweep_gen #(.N_IN(2), .SETTLE(1)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .sw    (a_if.slave)
   );

   tt_sweep_gen #(.N_IN(3), .SETTLE(2)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .sw    (b_if.slave)
   );

   // Gates under test: combinational lookup of the driven vector.
   assign a_if.dut_y = a_gate[a_if.vec_out];
   assign b_if.dut_y = b_gate[b_if.vec_out];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Currently observed instance.
   bit         sel;
   logic [7:0] cur_tbl;
   logic [3:0] cur_err;
   logic [2:0] cur_vec;
   logic [2:0] cur_fail;
   logic       cur_valid, cur_busy, cur_done, cur_pass;

   assign cur_tbl   = sel ? b_if.table_out : {4'b0000, a_if.table_out};
   assign cur_err   = sel ? b_if.err_count : {1'b0, a_if.err_count};
   assign cur_vec   = sel ? b_if.vec_out   : {1'b0, a_if.vec_out};
   assign cur_fail  = sel ? b_if.fail_vec  : {1'b0, a_if.fail_vec};
   assign cur_valid = sel ? b_if.vec_valid : a_if.vec_valid;
   assign cur_busy  = sel ? b_if.busy      : a_if.busy;
   assign cur_done  = sel ? b_if.done      : a_if.done;
   assign cur_pass  = sel ? b_if.pass      : a_if.pass;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Sweep outcome from truth tables: measured table equals the gate table,
   // errors are the differing bits, fail vector is the lowest differing index.
   task automatic model(input int n, input int s, input logic [7:0] g, input logic [7:0] e,
                        output logic [7:0] tbl, output int err, output int fv, output int len);
      int nv;
      logic [7:0] mask, diff;
      nv   = 1 << n;
      mask = 8'((1 << nv) - 1);
      diff = (g ^ e) & mask;
      tbl  = g & mask;
      err  = 0;
      fv   = -1;
      for (int i = 0; i < nv; i++) begin
         if (diff[i]) begin
            err++;
            if (fv < 0) fv = i;
         end
      end
      len = nv * (s + 1);
`ifdef TT_SWEEP_STOP_ON_ERR_EN
      if (err > 0) begin
         err = 1;
         tbl = g & 8'((2 << fv) - 1);
         len = (fv + 1) * (s + 1);
      end
`endif
      if (fv < 0) fv = 0;
   endtask

   task automatic set_start(input bit v);
      if (sel) b_if.start = v;
      else     a_if.start = v;
   endtask

   task automatic check_quiet(input string tag);
      check_val({tag, "_busy"},  32'(cur_busy),  32'd0);
      check_val({tag, "_valid"}, 32'(cur_valid), 32'd0);
      check_val({tag, "_vec"},   32'(cur_vec),   32'd0);
      check_val({tag, "_done"},  32'(cur_done),  32'd0);
   endtask

   task automatic check_cleared(input string tag);
      check_val({tag, "_tbl"},  32'(cur_tbl),  32'd0);
      check_val({tag, "_err"},  32'(cur_err),  32'd0);
      check_val({tag, "_fail"}, 32'(cur_fail), 32'd0);
      check_val({tag, "_pass"}, 32'(cur_pass), 32'd0);
   endtask

   // Runs nsw back-to-back sweeps (start held high until the last accept)
   // and checks every cycle against the model.
   task automatic run_sweep(input bit s_sel, input logic [7:0] g, input logic [7:0] e, input int nsw);
      int n, s, err, fv, len;
      logic [7:0] tbl;
      sel = s_sel;
      n   = s_sel ? 3 : 2;
      s   = s_sel ? 2 : 1;
      if (s_sel) begin
         b_gate = g;
         b_if.expected = e;
      end else begin
         a_gate = g[3:0];
         a_if.expected = e[3:0];
      end
      model(n, s, g, e, tbl, err, fv, len);
      set_start(1'b1);
      for (int w = 0; w < nsw; w++) begin
         @(posedge clk); #1;
         if (w == nsw - 1) set_start(1'b0);
         check_quiet("accept");
         check_cleared("accept");
         for (int k = 1; k <= len; k++) begin
            @(posedge clk); #1;
            check_val("sweep_valid", 32'(cur_valid), 32'd1);
            check_val("sweep_busy",  32'(cur_busy),  32'd1);
            check_val("sweep_vec",   32'(cur_vec),   32'((k - 1) / (s + 1)));
            check_val("sweep_done",  32'(cur_done),  32'd0);
         end
         @(posedge clk); #1;
         check_val("end_done",  32'(cur_done),  32'd1);
         check_val("end_busy",  32'(cur_busy),  32'd0);
         check_val("end_valid", 32'(cur_valid), 32'd0);
         check_val("end_vec",   32'(cur_vec),   32'd0);
         check_val("end_tbl",   32'(cur_tbl),   32'(tbl));
         check_val("end_err",   32'(cur_err),   32'(err));
         check_val("end_fail",  32'(cur_fail),  32'(fv));
         check_val("end_pass",  32'(cur_pass),  32'(err == 0));
      end
      repeat (2) begin
         @(posedge clk); #1;
         check_quiet("hold");
         check_val("hold_tbl",  32'(cur_tbl),  32'(tbl));
         check_val("hold_err",  32'(cur_err),  32'(err));
         check_val("hold_fail", 32'(cur_fail), 32'(fv));
         check_val("hold_pass", 32'(cur_pass), 32'(err == 0));
      end
   endtask

   initial begin
      logic [7:0] g, e;
      bit         rs;
      rst_n = 1'b0;
      a_if.start = 1'b0;  a_if.expected = 4'h0;
      b_if.start = 1'b0;  b_if.expected = 8'h00;
      a_gate = 4'b1000;   b_gate = 8'b1110_1000;
      sel = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      // Reset state of both instances.
      sel = 1'b0; #0; check_quiet("rst_a"); check_cleared("rst_a");
      sel = 1'b1; #0; check_quiet("rst_b"); check_cleared("rst_b");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // AND gate with matching mask, then with an OR mask.
      run_sweep(1'b0, 8'h08, 8'h08, 1);
      run_sweep(1'b0, 8'h08, 8'h0E, 1);
      // Stuck-at-1 gate.
      run_sweep(1'b0, 8'h0F, 8'h08, 1);
      // 3-input majority on the N_IN=3, SETTLE=2 instance.
      run_sweep(1'b1, 8'hE8, 8'hE8, 1);
      // start held high across two sweeps: single done each, clean restart.
      run_sweep(1'b0, 8'h08, 8'h08, 2);

      // Reset mid-sweep while vector 2'b10 is on the gate.
      sel = 1'b0;
      a_gate = 4'b1110;  a_if.expected = 4'b1000;
      a_if.start = 1'b1;
      @(posedge clk); #1;
      a_if.start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check_val("mid_vec", 32'(cur_vec), 32'd2);
      check_val("mid_err", 32'(cur_err), 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_quiet("abort");
      check_cleared("abort");
      repeat (12) begin
         @(posedge clk); #1;
         check_val("abort_done", 32'(cur_done), 32'd0);
         check_val("abort_busy", 32'(cur_busy), 32'd0);
      end
      run_sweep(1'b0, 8'h08, 8'h08, 1);

      // Randomized gates and masks on both instances.
      for (int i = 0; i < 16; i++) begin
         rs = 1'($urandom_range(0, 1));
         g  = 8'($urandom);
         e  = ($urandom_range(0, 2) == 0) ? g : 8'($urandom);
         if (!rs) begin
            g = g & 8'h0F;
            e = e & 8'h0F;
         end
         run_sweep(rs, g, e, (i % 5 == 0) ? 2 : 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
